// File: rtl/mcu_sleep_pmu.sv
// Core-side power management unit: deep-sleep WIC/sleep-hold handshake, HCLK gating,
// timed wake-up and debug power-up acknowledge. Optional sleep cycle counter: MCU_SLEEP_PMU_SLEEPCNT_EN.
module mcu_sleep_pmu #(
    parameter int WAKE_DLY    = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        FCLK,
    input  logic        PORESETn,
    input  logic        SLEEPING,
    input  logic        SLEEPDEEP,
    input  logic        WAKEUP,
    input  logic        WICENACK,
    input  logic        SLEEPHOLDACKn,
    input  logic        CDBGPWRUPREQ,
    output logic        WICENREQ,
    output logic        SLEEPHOLDREQn,
    output logic        GATEHCLK,
    output logic        CDBGPWRUPACK
`ifdef MCU_SLEEP_PMU_SLEEPCNT_EN
    ,
    output logic [31:0] SLEEPCNT
`endif
);

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_WICREQ  = 3'd1;
    localparam logic [2:0] ST_HOLDREQ = 3'd2;
    localparam logic [2:0] ST_SLEEP   = 3'd3;
    localparam logic [2:0] ST_WAKE    = 3'd4;

    localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] WAKE_LAST = 8'(WAKE_DLY - 1);

    logic [2:0] r_state;
    logic [2:0] w_stateNext;
    logic [7:0] r_cnt;
    logic       r_wicReq;
    logic       r_holdReqN;
    logic       r_gate;
    logic       r_dbgAck;
    logic       w_wicReqNext;
    logic       w_holdReqNNext;
    logic       w_gateNext;
    logic       w_abort;
    logic       w_enterCnt;

    // Abort conditions shared by both handshake states; they outrank any acknowledge.
    assign w_abort = !SLEEPING || WAKEUP || CDBGPWRUPREQ;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_RUN: begin
                if (SLEEPING && SLEEPDEEP && !CDBGPWRUPREQ && !r_dbgAck)
                    w_stateNext = ST_WICREQ;
            end
            ST_WICREQ: begin
                if (w_abort || (r_cnt == ACK_LAST))
                    w_stateNext = ST_RUN;
                else if (WICENACK)
                    w_stateNext = ST_HOLDREQ;
            end
            ST_HOLDREQ: begin
                if (w_abort)
                    w_stateNext = ST_RUN;
                else if (!SLEEPHOLDACKn)
                    w_stateNext = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (WAKEUP || CDBGPWRUPREQ)
                    w_stateNext = ST_WAKE;
            end
            ST_WAKE: begin
                if (r_cnt == WAKE_LAST)
                    w_stateNext = ST_RUN;
            end
            default: w_stateNext = ST_RUN;
        endcase
    end

    // Outputs are decoded from the next state so they take effect on the same edge as the state.
    always_comb begin
        w_wicReqNext   = 1'b0;
        w_holdReqNNext = 1'b1;
        w_gateNext     = 1'b0;
        case (w_stateNext)
            ST_WICREQ: begin
                w_wicReqNext = 1'b1;
            end
            ST_HOLDREQ, ST_WAKE: begin
                w_wicReqNext   = 1'b1;
                w_holdReqNNext = 1'b0;
            end
            ST_SLEEP: begin
                w_wicReqNext   = 1'b1;
                w_holdReqNNext = 1'b0;
                w_gateNext     = 1'b1;
            end
            default: begin
                w_wicReqNext   = 1'b0;
                w_holdReqNNext = 1'b1;
                w_gateNext     = 1'b0;
            end
        endcase
    end

    assign w_enterCnt = (w_stateNext != r_state) &&
                        ((w_stateNext == ST_WICREQ) || (w_stateNext == ST_WAKE));

    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            r_state    <= ST_RUN;
            r_cnt      <= 8'd0;
            r_wicReq   <= 1'b0;
            r_holdReqN <= 1'b1;
            r_gate     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_wicReq   <= w_wicReqNext;
            r_holdReqN <= w_holdReqNNext;
            r_gate     <= w_gateNext;
            if (w_enterCnt)
                r_cnt <= 8'd0;
            else if ((r_state == ST_WICREQ) || (r_state == ST_WAKE))
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // A new acknowledge is only granted from RUN; dropping the request clears it anywhere.
    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn)
            r_dbgAck <= 1'b0;
        else
            r_dbgAck <= CDBGPWRUPREQ && (r_dbgAck || (r_state == ST_RUN));
    end

    assign WICENREQ      = r_wicReq;
    assign SLEEPHOLDREQn = r_holdReqN;
    assign GATEHCLK      = r_gate;
    assign CDBGPWRUPACK  = r_dbgAck;

`ifdef MCU_SLEEP_PMU_SLEEPCNT_EN
    logic [31:0] r_sleepCnt;

    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn)
            r_sleepCnt <= 32'd0;
        else if ((w_stateNext == ST_SLEEP) && (r_state != ST_SLEEP))
            r_sleepCnt <= 32'd0;
        else if (r_gate && (r_sleepCnt != 32'hFFFF_FFFF))
            r_sleepCnt <= r_sleepCnt + 32'd1;
    end

    assign SLEEPCNT = r_sleepCnt;
`endif

`ifndef SYNTHESIS
    a_wakeDlyRange : assert property (@(posedge FCLK) (WAKE_DLY >= 1) && (WAKE_DLY <= 255));
    a_ackTimeoutRange : assert property (@(posedge FCLK) (ACK_TIMEOUT >= 1) && (ACK_TIMEOUT <= 255));
`endif

endmodule

// File: tb/tb_mcu_sleep_pmu.sv
// Table-driven bench for mcu_sleep_pmu with an expected-output scoreboard queue.
module tb_mcu_sleep_pmu;

    logic FCLK = 1'b0;
    logic PORESETn = 1'b0;
    logic SLEEPING = 1'b0;
    logic SLEEPDEEP = 1'b0;
    logic WAKEUP = 1'b0;
    logic WICENACK = 1'b0;
    logic SLEEPHOLDACKn = 1'b1;
    logic CDBGPWRUPREQ = 1'b0;
    logic WICENREQ;
    logic SLEEPHOLDREQn;
    logic GATEHCLK;
    logic CDBGPWRUPACK;
`ifdef MCU_SLEEP_PMU_SLEEPCNT_EN
    logic [31:0] SLEEPCNT;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        string name;
        logic  slp, deep, wake, wicAck, holdAckN, dbgReq;
        logic  expWic, expHoldN, expGate, expDbgAck;
    } vec_t;

    typedef struct {
        string name;
        logic  wic, holdN, gate, dbgAck;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];

    mcu_sleep_pmu #(.WAKE_DLY(4), .ACK_TIMEOUT(16)) dut (
        .FCLK(FCLK),
        .PORESETn(PORESETn),
        .SLEEPING(SLEEPING),
        .SLEEPDEEP(SLEEPDEEP),
        .WAKEUP(WAKEUP),
        .WICENACK(WICENACK),
        .SLEEPHOLDACKn(SLEEPHOLDACKn),
        .CDBGPWRUPREQ(CDBGPWRUPREQ),
        .WICENREQ(WICENREQ),
        .SLEEPHOLDREQn(SLEEPHOLDREQn),
        .GATEHCLK(GATEHCLK),
        .CDBGPWRUPACK(CDBGPWRUPACK)
`ifdef MCU_SLEEP_PMU_SLEEPCNT_EN
        ,
        .SLEEPCNT(SLEEPCNT)
`endif
    );

    always #5 FCLK = ~FCLK;

    function automatic vec_t mk(string name, logic slp, logic deep, logic wake, logic wicAck,
                                logic holdAckN, logic dbgReq, logic eWic, logic eHoldN,
                                logic eGate, logic eDbgAck);
        vec_t v;
        v.name = name;
        v.slp = slp; v.deep = deep; v.wake = wake; v.wicAck = wicAck;
        v.holdAckN = holdAckN; v.dbgReq = dbgReq;
        v.expWic = eWic; v.expHoldN = eHoldN; v.expGate = eGate; v.expDbgAck = eDbgAck;
        return v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        SLEEPING      = v.slp;
        SLEEPDEEP     = v.deep;
        WAKEUP        = v.wake;
        WICENACK      = v.wicAck;
        SLEEPHOLDACKn = v.holdAckN;
        CDBGPWRUPREQ  = v.dbgReq;
        e.name = v.name;
        e.wic = v.expWic; e.holdN = v.expHoldN; e.gate = v.expGate; e.dbgAck = v.expDbgAck;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty got=0 want=1 at %0t", $time);
        end else begin
            e = expQ.pop_front();
            check1({e.name, ".WICENREQ"},      32'(WICENREQ),      32'(e.wic));
            check1({e.name, ".SLEEPHOLDREQn"}, 32'(SLEEPHOLDREQn), 32'(e.holdN));
            check1({e.name, ".GATEHCLK"},      32'(GATEHCLK),      32'(e.gate));
            check1({e.name, ".CDBGPWRUPACK"},  32'(CDBGPWRUPACK),  32'(e.dbgAck));
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(posedge FCLK);
        #1;
        checkOutput();
    endtask

    initial begin
        // Full cycle, aborts, SLEEPING ignored in SLEEP, and debug power-up handling.
        vecs.push_back(mk("run_idle",         0,0,0,0,1,0, 0,1,0,0));
        vecs.push_back(mk("fc_wicreq",        1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("fc_wait_ack",      1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("fc_holdreq",       1,1,0,1,1,0, 1,0,0,0));
        vecs.push_back(mk("fc_wait_hack1",    1,1,0,0,1,0, 1,0,0,0));
        vecs.push_back(mk("fc_wait_hack2",    1,1,0,0,1,0, 1,0,0,0));
        vecs.push_back(mk("fc_sleep",         1,1,0,0,0,0, 1,0,1,0));
        vecs.push_back(mk("fc_sleep_hold",    1,1,0,0,0,0, 1,0,1,0));
        vecs.push_back(mk("fc_wake",          1,1,1,0,0,0, 1,0,0,0));
        vecs.push_back(mk("fc_wake_dly1",     0,0,0,0,1,0, 1,0,0,0));
        vecs.push_back(mk("fc_wake_dly2",     0,0,0,0,1,0, 1,0,0,0));
        vecs.push_back(mk("fc_wake_dly3",     0,0,0,0,1,0, 1,0,0,0));
        vecs.push_back(mk("fc_run",           0,0,0,0,1,0, 0,1,0,0));
        vecs.push_back(mk("hr_enter_wic",     1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("hr_enter_hold",    1,1,0,1,1,0, 1,0,0,0));
        vecs.push_back(mk("hr_abort_slp",     0,0,0,1,1,0, 0,1,0,0));
        vecs.push_back(mk("wr_enter",         1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("wr_abort_vs_ack",  0,1,0,1,1,0, 0,1,0,0));
        vecs.push_back(mk("hr2_enter_wic",    1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("hr2_enter_hold",   1,1,0,1,1,0, 1,0,0,0));
        vecs.push_back(mk("hr_wake_vs_hack",  1,1,1,0,0,0, 0,1,0,0));
        vecs.push_back(mk("run_wake_ignored", 1,1,1,0,1,0, 1,1,0,0));
        vecs.push_back(mk("wr_wake_abort",    1,1,1,0,1,0, 0,1,0,0));
        vecs.push_back(mk("idle1",            0,0,0,0,1,0, 0,1,0,0));
        vecs.push_back(mk("s2_wic",           1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("s2_hold",          1,1,0,1,1,0, 1,0,0,0));
        vecs.push_back(mk("s2_sleep",         1,1,0,0,0,0, 1,0,1,0));
        vecs.push_back(mk("s2_slp_low1",      0,0,0,0,0,0, 1,0,1,0));
        vecs.push_back(mk("s2_slp_low2",      0,0,0,0,1,0, 1,0,1,0));
        vecs.push_back(mk("s2_wake",          0,0,1,0,1,0, 1,0,0,0));
        vecs.push_back(mk("s2_wake_dly1",     0,0,0,0,1,0, 1,0,0,0));
        vecs.push_back(mk("s2_wake_dly2",     0,0,0,0,1,0, 1,0,0,0));
        vecs.push_back(mk("s2_wake_dly3",     0,0,0,0,1,0, 1,0,0,0));
        vecs.push_back(mk("s2_run",           0,0,0,0,1,0, 0,1,0,0));
        vecs.push_back(mk("d_wic",            1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("d_hold",           1,1,0,1,1,0, 1,0,0,0));
        vecs.push_back(mk("d_sleep",          1,1,0,0,0,0, 1,0,1,0));
        vecs.push_back(mk("d_req_in_sleep",   1,1,0,0,0,1, 1,0,0,0));
        vecs.push_back(mk("d_wake_noack1",    1,1,0,0,1,1, 1,0,0,0));
        vecs.push_back(mk("d_wake_noack2",    1,1,0,0,1,1, 1,0,0,0));
        vecs.push_back(mk("d_wake_noack3",    1,1,0,0,1,1, 1,0,0,0));
        vecs.push_back(mk("d_run",            1,1,0,0,1,1, 0,1,0,0));
        vecs.push_back(mk("d_ack",            1,1,0,0,1,1, 0,1,0,1));
        vecs.push_back(mk("d_ack_drop",       1,1,0,0,1,0, 0,1,0,0));
        vecs.push_back(mk("d_reenter",        1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("d_abort",          0,0,0,0,1,0, 0,1,0,0));
        vecs.push_back(mk("dw_wic",           1,1,0,0,1,0, 1,1,0,0));
        vecs.push_back(mk("dw_abort_vs_ack",  1,1,0,1,1,1, 0,1,0,0));
        vecs.push_back(mk("dw_ack",           0,0,0,0,1,1, 0,1,0,1));
        vecs.push_back(mk("dw_drop",          0,0,0,0,1,0, 0,1,0,0));

        repeat (2) @(posedge FCLK);
        #1;
        check1("reset.WICENREQ",      32'(WICENREQ),      32'd0);
        check1("reset.SLEEPHOLDREQn", 32'(SLEEPHOLDREQn), 32'd1);
        check1("reset.GATEHCLK",      32'(GATEHCLK),      32'd0);
        check1("reset.CDBGPWRUPACK",  32'(CDBGPWRUPACK),  32'd0);
        PORESETn = 1'b1;

        foreach (vecs[i]) runVec(vecs[i]);

        for (int i = 0; i < 50; i++)
            runVec(mk("plain_sleep", 1,0,0,0,1,0, 0,1,0,0));

        // WIC never acknowledges: WICENREQ holds for ACK_TIMEOUT cycles, then RUN, then retry.
        for (int i = 0; i < 16; i++)
            runVec(mk("wic_timeout_hold", 1,1,0,0,1,0, 1,1,0,0));
        runVec(mk("wic_timeout_run",     1,1,0,0,1,0, 0,1,0,0));
        runVec(mk("wic_timeout_reentry", 1,1,0,0,1,0, 1,1,0,0));
        runVec(mk("wic_timeout_abort",   0,0,0,0,1,0, 0,1,0,0));

        // Reset asserted mid-SLEEP, away from any clock edge.
        runVec(mk("rs_wic",    1,1,0,0,1,0, 1,1,0,0));
        runVec(mk("rs_hold",   1,1,0,1,1,0, 1,0,0,0));
        runVec(mk("rs_sleep",  1,1,0,0,0,0, 1,0,1,0));
`ifdef MCU_SLEEP_PMU_SLEEPCNT_EN
        check1("sleepcnt_entry", SLEEPCNT, 32'd0);
`endif
        runVec(mk("rs_sleep2", 1,1,0,0,0,0, 1,0,1,0));
        runVec(mk("rs_sleep3", 1,1,0,0,0,0, 1,0,1,0));
`ifdef MCU_SLEEP_PMU_SLEEPCNT_EN
        check1("sleepcnt_count", SLEEPCNT, 32'd2);
`endif
        #3;
        PORESETn = 1'b0;
        #1;
        check1("rst_mid.GATEHCLK",      32'(GATEHCLK),      32'd0);
        check1("rst_mid.WICENREQ",      32'(WICENREQ),      32'd0);
        check1("rst_mid.SLEEPHOLDREQn", 32'(SLEEPHOLDREQn), 32'd1);
        check1("rst_mid.CDBGPWRUPACK",  32'(CDBGPWRUPACK),  32'd0);
`ifdef MCU_SLEEP_PMU_SLEEPCNT_EN
        check1("rst_mid.SLEEPCNT", SLEEPCNT, 32'd0);
`endif
        @(posedge FCLK);
        #1;
        PORESETn = 1'b1;
        runVec(mk("post_reset_idle", 0,0,0,0,1,0, 0,1,0,0));
        runVec(mk("post_reset_wic",  1,1,0,0,1,0, 1,1,0,0));

        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_leftover got=%0d want=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
